// File: rtl/conv_mem_sequencer_pkg.sv
// Shared widths and sequencer state encoding for the Conv / bram_memory datapath.
package conv_mem_sequencer_pkg;

  localparam int DEF_BIT_LEN    = 8;
  localparam int DEF_RAM_WIDTH  = 13;
  localparam int DEF_NB_ADDRESS = 10;
  localparam int DEF_M_LEN      = 3;
  localparam int DEF_CONV_LAT   = 6;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_K = 3'd1,
    ST_RUN    = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } seq_state_e;

endpackage

// File: rtl/conv_mem_sequencer_latency_valid_pipe.sv
// DEPTH-deep valid shift register with advance enable, clear and empty flag.
module latency_valid_pipe #(
  parameter int DEPTH = 6
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  input  logic din,
  output logic dout,
  output logic empty
);

  logic [DEPTH-1:0] pipe_q, pipe_d;

  always_comb begin
    pipe_d = pipe_q;
    if (clr) begin
      pipe_d = '0;
    end else if (en) begin
      pipe_d[0] = din;
      for (int i = 1; i < DEPTH; i++) begin
        pipe_d[i] = pipe_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) pipe_q <= '0;
    else        pipe_q <= pipe_d;
  end

  assign dout  = pipe_q[DEPTH-1];
  assign empty = (pipe_q == '0);

endmodule

// File: rtl/conv_mem_sequencer.sv
// Sequences kernel load, image streaming and latency-aligned write-back for one Conv pass.
module conv_mem_sequencer
  import conv_mem_sequencer_pkg::*;
#(
  parameter int BIT_LEN    = DEF_BIT_LEN,
  parameter int RAM_WIDTH  = DEF_RAM_WIDTH,
  parameter int NB_ADDRESS = DEF_NB_ADDRESS,
  parameter int M_LEN      = DEF_M_LEN,
  parameter int CONV_LAT   = DEF_CONV_LAT
) (
  input  logic                  CLK100MHZ,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic                  i_abort,
  input  logic                  i_en,
  input  logic [NB_ADDRESS-1:0] i_last_addr,
  input  logic [NB_ADDRESS-1:0] i_micro_addr,
  input  logic                  i_k_valid,
  output logic                  o_k_ready,
  output logic                  o_selecK_I,
  output logic                  o_conv_valid,
  input  logic [RAM_WIDTH-1:0]  i_conv_data,
  output logic [NB_ADDRESS-1:0] o_rd_addr,
  output logic [NB_ADDRESS-1:0] o_wr_addr,
  output logic                  o_wr_en,
  output logic [RAM_WIDTH-1:0]  o_wr_data,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int              KCNT_W = $clog2(M_LEN + 1);
  localparam logic [KCNT_W-1:0] K_LAST = KCNT_W'(M_LEN - 1);

  seq_state_e            state_q, state_d;
  logic [KCNT_W-1:0]     kcnt_q, kcnt_d;
  logic [NB_ADDRESS-1:0] rd_q, rd_d;
  logic [NB_ADDRESS-1:0] wr_q, wr_d;
  logic [NB_ADDRESS-1:0] last_q, last_d;
  logic                  wr_en_q, wr_en_d;
  logic [RAM_WIDTH-1:0]  wr_data_q, wr_data_d;
  logic                  done_q, done_d;

  logic pipe_en, pipe_in, pipe_out, pipe_empty;
  logic k_accept, wr_fire;

  latency_valid_pipe #(.DEPTH(CONV_LAT)) u_vpipe (
    .clk   (CLK100MHZ),
    .rst_n (i_reset),
    .en    (pipe_en),
    .clr   (i_abort),
    .din   (pipe_in),
    .dout  (pipe_out),
    .empty (pipe_empty)
  );

  always_comb begin
    state_d      = state_q;
    kcnt_d       = kcnt_q;
    rd_d         = rd_q;
    wr_d         = wr_q;
    last_d       = last_q;
    wr_en_d      = wr_en_q;
    wr_data_d    = wr_data_q;
    done_d       = done_q;
    o_selecK_I   = 1'b0;
    o_k_ready    = 1'b0;
    o_conv_valid = 1'b0;
    o_rd_addr    = rd_q;
    pipe_en      = 1'b0;
    pipe_in      = 1'b0;
    k_accept     = 1'b0;

    // A registered write is held through a stall and retired on the next enabled cycle.
    wr_fire = wr_en_q & i_en;
    if (wr_fire) wr_d = wr_q + 1'b1;
    if (i_en) begin
      wr_en_d   = pipe_out;
      wr_data_d = i_conv_data;
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        o_rd_addr = i_micro_addr;
        if (state_q == ST_DONE) state_d = ST_IDLE;
        if (i_start) begin
          state_d = ST_LOAD_K;
          last_d  = i_last_addr;
          kcnt_d  = '0;
          rd_d    = '0;
          wr_d    = '0;
          done_d  = 1'b0;
        end
      end
      ST_LOAD_K: begin
        o_k_ready    = i_en;
        k_accept     = i_k_valid & i_en;
        o_conv_valid = k_accept;
        if (k_accept) begin
          kcnt_d = kcnt_q + 1'b1;
          if (kcnt_q == K_LAST) state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        o_selecK_I   = 1'b1;
        o_conv_valid = i_en;
        pipe_en      = i_en;
        pipe_in      = 1'b1;
        if (i_en) begin
          if (rd_q == last_q) state_d = ST_DRAIN;
          else                rd_d    = rd_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        o_selecK_I   = 1'b1;
        o_conv_valid = i_en;
        pipe_en      = i_en;
        // Leave only once the final pending write has actually been retired.
        if (pipe_empty && (i_en || !wr_en_q)) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (i_abort) begin
      state_d = ST_IDLE;
      done_d  = 1'b0;
      wr_en_d = 1'b0;
    end
  end

  always_ff @(posedge CLK100MHZ) begin
    if (!i_reset) begin
      state_q   <= ST_IDLE;
      kcnt_q    <= '0;
      rd_q      <= '0;
      wr_q      <= '0;
      last_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      kcnt_q    <= kcnt_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      last_q    <= last_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
    end
  end

  assign o_wr_en   = wr_en_q & i_en;
  assign o_wr_addr = wr_q;
  assign o_wr_data = wr_data_q;
  assign o_busy    = (state_q == ST_LOAD_K) || (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign o_done    = done_q;

endmodule

// File: tb/tb_conv_mem_sequencer.sv
// Directed bench for conv_mem_sequencer with a behavioural bram+Conv latency model.
module tb_conv_mem_sequencer;

  localparam int RW  = 13;
  localparam int AW  = 10;
  localparam int LAT = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          en = 1'b0;
  logic          k_valid = 1'b0;
  logic [AW-1:0] last_addr = '0;
  logic [AW-1:0] micro_addr = '0;
  logic [RW-1:0] conv_data;
  logic          k_ready, sel_ki, conv_valid, wr_en, busy, done;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [RW-1:0] wr_data;
  logic [RW-1:0] dp [LAT];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  conv_mem_sequencer #(
    .BIT_LEN(8), .RAM_WIDTH(RW), .NB_ADDRESS(AW), .M_LEN(3), .CONV_LAT(LAT)
  ) dut (
    .CLK100MHZ    (clk),
    .i_reset      (rst_n),
    .i_start      (start),
    .i_abort      (abort),
    .i_en         (en),
    .i_last_addr  (last_addr),
    .i_micro_addr (micro_addr),
    .i_k_valid    (k_valid),
    .o_k_ready    (k_ready),
    .o_selecK_I   (sel_ki),
    .o_conv_valid (conv_valid),
    .i_conv_data  (conv_data),
    .o_rd_addr    (rd_addr),
    .o_wr_addr    (wr_addr),
    .o_wr_en      (wr_en),
    .o_wr_data    (wr_data),
    .o_busy       (busy),
    .o_done       (done)
  );

  function automatic logic [RW-1:0] pixel(input int a);
    int t;
    t = a * 37 + 5;
    return t[RW-1:0];
  endfunction

  // bram read + Conv pipeline: result for address A appears LAT enabled cycles after A is issued
  always @(posedge clk) begin
    if (en) begin
      dp[0] <= pixel(int'(rd_addr));
      for (int i = 1; i < LAT; i++) dp[i] <= dp[i-1];
    end
  end
  assign conv_data = dp[LAT-1];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One pass: start, gapped kernel load, run until done, or stop by abort/reset at cycle stop_c
  task automatic applyStimulus(input int last, input bit stall, input int abort_c, input int reset_c);
    int  pulses, c, rd_exp, wcount, first_wr_c, last_wr_c;
    bit  done_seen, stopped;
    last_addr = AW'(last);
    start = 1'b1; abort = 1'b0; en = 1'b1; k_valid = 1'b0;
    tick();
    start = 1'b0;
    last_addr = ~AW'(last);
    checkOutput("start_busy", busy, 1);
    checkOutput("start_done_clr", done, 0);
    pulses = 0;
    for (int j = 0; j < 5; j++) begin
      k_valid = (j % 2 == 0);
      en = 1'b1;
      #1;
      checkOutput("kload_sel", sel_ki, 0);
      checkOutput("kload_ready", k_ready, 1);
      if (conv_valid) pulses++;
      tick();
    end
    k_valid = 1'b1;
    checkOutput("kload_pulses", pulses, 3);
    rd_exp = 0; wcount = 0; first_wr_c = -1; last_wr_c = -1;
    done_seen = 1'b0; stopped = 1'b0;
    c = 0;
    while (c < (last + 1) * 3 + 60 && !done_seen && !stopped) begin
      en    = stall ? (c % 4 == 0 || c % 4 == 3) : 1'b1;
      start = (c == 10 && last > 20);
      abort = (c == abort_c);
      rst_n = !(c == reset_c);
      #1;
      if (c == 0) checkOutput("run_sel", sel_ki, 1);
      checkOutput("kvalid_ignored", k_ready, 0);
      if (busy) checkOutput("conv_valid", conv_valid, en);
      if (!en) checkOutput("stall_wr_en", wr_en, 0);
      if (busy) checkOutput("rd_addr", rd_addr, (rd_exp > last) ? last : rd_exp);
      if (busy && en && rd_exp <= last) rd_exp++;
      if (wr_en) begin
        checkOutput("wr_addr", wr_addr, wcount);
        checkOutput("wr_data", wr_data, pixel(wcount));
        if (first_wr_c < 0) first_wr_c = c;
        last_wr_c = c;
        wcount++;
      end
      if (done) begin
        done_seen = 1'b1;
        checkOutput("done_timing", c, last_wr_c + 1);
        checkOutput("wr_count", wcount, last + 1);
        checkOutput("rd_count", rd_exp, last + 1);
      end
      if (c == abort_c || c == reset_c) stopped = 1'b1;
      tick();
      c++;
    end
    start = 1'b0; abort = 1'b0; rst_n = 1'b1; k_valid = 1'b0; en = 1'b1;
    if (stopped) begin
      for (int j = 0; j < 8; j++) begin
        #1;
        checkOutput("stop_busy", busy, 0);
        checkOutput("stop_wr_en", wr_en, 0);
        checkOutput("stop_done", done, 0);
        tick();
      end
    end else begin
      checkOutput("done_seen", done_seen, 1);
      if (!stall) checkOutput("first_wr_lat", first_wr_c, LAT + 1);
      #1;
      checkOutput("done_sticky", done, 1);
      checkOutput("idle_busy", busy, 0);
      checkOutput("idle_rd_mux", rd_addr, micro_addr);
    end
  endtask

  initial begin
    $display("[TB] reset");
    rst_n = 1'b0;
    micro_addr = 10'h2A;
    tick();
    tick();
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_wr_en", wr_en, 0);
    checkOutput("rst_rd_addr", rd_addr, 10'h2A);
    checkOutput("rst_conv_valid", conv_valid, 0);
    checkOutput("rst_wr_addr", wr_addr, 0);
    micro_addr = 10'h155;
    #1;
    checkOutput("rst_rd_mux", rd_addr, 10'h155);
    rst_n = 1'b1;
    en = 1'b1;
    tick();
    k_valid = 1'b1;
    #1;
    checkOutput("idle_kvalid_ready", k_ready, 0);
    checkOutput("idle_kvalid_cv", conv_valid, 0);
    k_valid = 1'b0;

    $display("[TB] full pass last=440");
    applyStimulus(440, 1'b0, -1, -1);

    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    #1;
    checkOutput("start_abort_busy", busy, 0);
    checkOutput("start_abort_done", done, 0);

    $display("[TB] stalled pass last=440");
    applyStimulus(440, 1'b1, -1, -1);
    $display("[TB] boundary last=0");
    applyStimulus(0, 1'b0, -1, -1);
    $display("[TB] boundary last=1023");
    applyStimulus(1023, 1'b0, -1, -1);
    $display("[TB] abort at rd=100");
    applyStimulus(440, 1'b0, 100, -1);
    applyStimulus(5, 1'b0, -1, -1);
    $display("[TB] reset mid-drain");
    applyStimulus(20, 1'b0, -1, 25);
    applyStimulus(3, 1'b1, -1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
